audio_gain_unit: RTL and testbench
==================================

Name: audio_gain_unit

Overview:
Stereo digital gain stage that sits directly downstream of the APB control unit. It consumes the control unit's tick/sample/level/clear/play outputs and produces gain-scaled left and right samples with a valid strobe for the DSP/output path. A single shared signed-by-unsigned multiplier is time-multiplexed over left and right channels by a small FSM. Results are saturated to the sample width.

Parameters:
DATA_W, 24, sample width (two's complement)
GAIN_W, 16, gain width (unsigned fixed point)
GAIN_FRAC, 15, gain fractional bits (0x8000 = unity)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; asynchronous, active-high
tick_in  in  1  sample strobe (control unit tick_out)
play_in  in  1  play mode (control unit play_out)
audio0_in  in  DATA_W  left sample (control unit audio0_out)
audio1_in  in  DATA_W  right sample (control unit audio1_out)
level_in  in  1  level-load pulse (control unit level_out)
level_reg_in  in  32  [31:16] left gain, [15:0] right gain (control unit level_reg_out)
clr_in  in  1  clear pulse (control unit clr_out)
audio0_out  out  DATA_W  scaled left sample
audio1_out  out  DATA_W  scaled right sample
valid_out  out  1  one-cycle strobe, outputs updated
busy_out  out  1  high in MUL_L, MUL_R, DONE
overrun_out  out  1  sticky: tick arrived while MUL_L/MUL_R

Behaviour:
- Reset: audio0_out=0, audio1_out=0, valid_out=0, busy_out=0, overrun_out=0, FSM=IDLE; shadow and active gains = 0x8000 both channels.
- level_in=1: shadow_l<=level_reg_in[31:16], shadow_r<=level_reg_in[15:0]. Active gains copied from shadow only on tick acceptance, so one sample never mixes two gain settings. level_in in the same cycle as an accepted tick: the new value is used for that tick.
- Tick acceptance: tick_in=1 && play_in=1 && state in {IDLE, DONE} && clr_in=0. On accept: latch audio0_in/audio1_in, load active gains, go to MUL_L.
- FSM: IDLE -> MUL_L (accept) -> MUL_R -> DONE -> IDLE (or MUL_L if a tick is accepted in DONE).
- MUL_L: product_l = signed(sample_l) * unsigned(gain_l), DATA_W+GAIN_W+1 bits, registered. MUL_R: same for the right channel, using the shared multiplier.
- Entering DONE: result = product >>> GAIN_FRAC (arithmetic shift, truncation toward -inf), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Both outputs update together and valid_out=1 in DONE only.
- Latency: tick_in high in cycle 0 -> valid_out high in cycle 3 for exactly one cycle. Sustained throughput is one sample per 3 cycles.
- Outputs hold their value between valid strobes.
- Tick during MUL_L/MUL_R: ignored, overrun_out<=1 (sticky). Tick with play_in=0: ignored, no overrun.
- clr_in=1 (highest priority): FSM<=IDLE and the in-flight sample is discarded. Next cycle: audio0_out=0, audio1_out=0, valid_out=0, overrun_out=0. Gains (shadow and active) are unchanged.
- play_in falling mid-operation: the current sample completes normally.
- Reset mid-operation: immediate return to reset values, asynchronously.

Optional Feature:
GAIN_ROUND_EN:
- Defined: add 2^(GAIN_FRAC-1) to the product before the shift (round half up), then saturate.
- Undefined: pure truncation, as in Behaviour.

Test Plan:
- Unity gain (reset defaults), audio0=0x100000, audio1=0xF00000, tick -> valid_out in cycle 3, audio0_out=0x100000, audio1_out=0xF00000.
- level_reg_in=0x40004000 + level_in, then tick with audio0=0x000100, audio1=0xFFFF00 -> 0x000080 / 0xFFFF80. With the same gain, 0x000003 / 0xFFFFFD -> 0x000001 / 0xFFFFFE; with GAIN_ROUND_EN -> 0x000002 / 0xFFFFFF.
- level_reg_in=0xFFFFFFFF, audio0=0x7FFFFF, audio1=0x800000 -> saturated 0x7FFFFF / 0x800000.
- Ticks in cycle 0 and cycle 1 -> single valid_out in cycle 3, overrun_out=1 from cycle 2. Then clr_in -> overrun_out=0, outputs=0.
- level_in pulse in cycle 1 (during MUL_L) with a new gain -> current sample uses the old gain; next tick uses the new gain.
- clr_in in cycle 2 after a tick -> no valid_out, outputs 0, FSM IDLE. play_in=0 with tick -> no valid_out, no overrun.

Source files
------------

// File: rtl/audio_gain_unit.sv
// audio_gain_unit: stereo gain stage, one shared multiplier time-multiplexed over L/R, saturating output.
// Optional GAIN_ROUND_EN adds round-half-up before the fractional shift.
module audio_gain_unit #(
    parameter int DATA_W    = 24,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              play_in,
    input  logic [DATA_W-1:0] audio0_in,
    input  logic [DATA_W-1:0] audio1_in,
    input  logic              level_in,
    input  logic [31:0]       level_reg_in,
    input  logic              clr_in,
    output logic [DATA_W-1:0] audio0_out,
    output logic [DATA_W-1:0] audio1_out,
    output logic              valid_out,
    output logic              busy_out,
    output logic              overrun_out
);
    localparam int P = DATA_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(2 ** GAIN_FRAC);
    localparam logic signed [P-1:0] SMAX = P'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [P-1:0] SMIN = -SMAX - 1;
`ifdef GAIN_ROUND_EN
    localparam logic signed [P-1:0] RND = P'(2 ** (GAIN_FRAC - 1));
`else
    localparam logic signed [P-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, DONE} state_t;
    state_t state, state_n;

    logic [GAIN_W-1:0]        shadow_l, shadow_r, gain_l, gain_r, mul_g;
    logic signed [DATA_W-1:0] sample_l, sample_r, mul_a;
    logic signed [P-1:0]      mul_p, product_l;
    logic                     accept, in_mul;

    function automatic logic [DATA_W-1:0] sat(input logic signed [P-1:0] p);
        logic signed [P-1:0] s;
        s = (p + RND) >>> GAIN_FRAC;
        return s > SMAX ? SMAX[DATA_W-1:0] : s < SMIN ? SMIN[DATA_W-1:0] : s[DATA_W-1:0];
    endfunction

    assign in_mul = state == MUL_L || state == MUL_R;
    assign accept = tick_in && play_in && !clr_in && (state == IDLE || state == DONE);
    assign mul_a  = state == MUL_R ? sample_r : sample_l;
    assign mul_g  = state == MUL_R ? gain_r : gain_l;
    // Zero-extended gain makes this a signed-by-unsigned product.
    assign mul_p  = P'(mul_a) * P'($signed({1'b0, mul_g}));

    always_comb begin
        state_n   = state;
        valid_out = state == DONE;
        busy_out  = state != IDLE;
        if (clr_in)
            state_n = IDLE;
        else if (accept)
            state_n = MUL_L;
        else
            state_n = state == MUL_L ? MUL_R : state == MUL_R ? DONE : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_l    <= UNITY;
            shadow_r    <= UNITY;
            gain_l      <= UNITY;
            gain_r      <= UNITY;
            sample_l    <= '0;
            sample_r    <= '0;
            product_l   <= '0;
            audio0_out  <= '0;
            audio1_out  <= '0;
            overrun_out <= 1'b0;
        end else begin
            if (level_in) begin
                shadow_l <= level_reg_in[31:16];
                shadow_r <= level_reg_in[15:0];
            end
            // A same-cycle level load takes effect for the sample being accepted.
            if (accept) begin
                sample_l <= audio0_in;
                sample_r <= audio1_in;
                gain_l   <= level_in ? level_reg_in[31:16] : shadow_l;
                gain_r   <= level_in ? level_reg_in[15:0] : shadow_r;
            end
            if (state == MUL_L)
                product_l <= mul_p;
            if (clr_in) begin
                audio0_out  <= '0;
                audio1_out  <= '0;
                overrun_out <= 1'b0;
            end else begin
                if (state == MUL_R) begin
                    audio0_out <= sat(product_l);
                    audio1_out <= sat(mul_p);
                end
                if (tick_in && play_in && in_mul)
                    overrun_out <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_gain_unit.sv
// tb_audio_gain_unit: directed and random stimulus against a cycle-level behavioural model of the gain stage.
module tb_audio_gain_unit;
    logic        clk = 0, rst = 1;
    logic        tick_in = 0, play_in = 0, level_in = 0, clr_in = 0;
    logic [23:0] audio0_in = 0, audio1_in = 0, audio0_out, audio1_out;
    logic [31:0] level_reg_in = 0;
    logic        valid_out, busy_out, overrun_out;

    audio_gain_unit dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .play_in(play_in),
        .audio0_in(audio0_in), .audio1_in(audio1_in), .level_in(level_in),
        .level_reg_in(level_reg_in), .clr_in(clr_in), .audio0_out(audio0_out),
        .audio1_out(audio1_out), .valid_out(valid_out), .busy_out(busy_out),
        .overrun_out(overrun_out)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit run = 0;

    int          cyc = 0, last_acc = -100;
    bit          alive = 0;
    logic [15:0] sh_l = 16'h8000, sh_r = 16'h8000;
    logic [23:0] res_l = 0, res_r = 0;
    logic [23:0] e_a0 = 0, e_a1 = 0, n_a0 = 0, n_a1 = 0;
    bit          e_v = 0, e_b = 0, e_o = 0, n_v = 0, n_b = 0, n_o = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", n, cyc, got, want);
        end
    endtask

    function automatic logic [23:0] ref_gain(input logic [23:0] s, input logic [15:0] g);
        longint p;
        p = longint'($signed(s)) * longint'(g);
`ifdef GAIN_ROUND_EN
        p = p + 16384;
`endif
        p = p >>> 15;
        if (p > 8388607) return 24'h7FFFFF;
        if (p < -8388608) return 24'h800000;
        return p[23:0];
    endfunction

    // Drive one clock cycle of inputs and advance the model to the following cycle.
    task automatic step(input bit t, input bit p, input logic [23:0] s0, input logic [23:0] s1,
                        input bit lv, input logic [31:0] lr, input bit c);
        bit in_mul;
        int d;
        @(posedge clk);
        #1;
        e_a0 = n_a0; e_a1 = n_a1; e_v = n_v; e_b = n_b; e_o = n_o;
        tick_in = t; play_in = p; audio0_in = s0; audio1_in = s1;
        level_in = lv; level_reg_in = lr; clr_in = c;
        in_mul = alive && (cyc - last_acc == 1 || cyc - last_acc == 2);
        if (c) begin
            n_a0 = 0; n_a1 = 0; n_o = 0; alive = 0;
        end else begin
            if (t && p && in_mul) n_o = 1;
            if (t && p && !in_mul) begin
                res_l = ref_gain(s0, lv ? lr[31:16] : sh_l);
                res_r = ref_gain(s1, lv ? lr[15:0] : sh_r);
                last_acc = cyc;
                alive = 1;
            end
        end
        d = cyc + 1 - last_acc;
        n_b = alive && d >= 1 && d <= 3;
        n_v = alive && d == 3;
        if (n_v) begin n_a0 = res_l; n_a1 = res_r; end
        if (lv) begin sh_l = lr[31:16]; sh_r = lr[15:0]; end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("cmp_audio0", audio0_out, e_a0);
            chk("cmp_audio1", audio1_out, e_a1);
            chk("cmp_valid", valid_out, e_v);
            chk("cmp_busy", busy_out, e_b);
            chk("cmp_overrun", overrun_out, e_o);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_audio0", audio0_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_overrun", overrun_out, 0);
        run = 1;
        // unity gain, latency 3
        step(1, 1, 24'h100000, 24'hF00000, 0, 0, 0);
        idle(1);
        chk("lat_busy", busy_out, 1);
        idle(1);
        chk("lat_novalid", valid_out, 0);
        idle(1);
        chk("unity_valid", valid_out, 1);
        chk("unity_a0", audio0_out, 24'h100000);
        chk("unity_a1", audio1_out, 24'hF00000);
        idle(1);
        chk("valid_one_cycle", valid_out, 0);
        chk("hold_a0", audio0_out, 24'h100000);
        // half gain
        step(0, 1, 0, 0, 1, 32'h40004000, 0);
        step(1, 1, 24'h000100, 24'hFFFF00, 0, 0, 0);
        idle(3);
        chk("half_a0", audio0_out, 24'h000080);
        chk("half_a1", audio1_out, 24'hFFFF80);
        idle(1);
        step(1, 1, 24'h000003, 24'hFFFFFD, 0, 0, 0);
        idle(3);
`ifdef GAIN_ROUND_EN
        chk("rnd_a0", audio0_out, 24'h000002);
        chk("rnd_a1", audio1_out, 24'hFFFFFF);
`else
        chk("trunc_a0", audio0_out, 24'h000001);
        chk("trunc_a1", audio1_out, 24'hFFFFFE);
`endif
        idle(1);
        // saturation
        step(1, 1, 24'h7FFFFF, 24'h800000, 1, 32'hFFFFFFFF, 0);
        idle(3);
        chk("sat_a0", audio0_out, 24'h7FFFFF);
        chk("sat_a1", audio1_out, 24'h800000);
        idle(1);
        // overrun then clear
        step(0, 1, 0, 0, 1, 32'h80008000, 0);
        step(1, 1, 24'h000010, 24'h000020, 0, 0, 0);
        step(1, 1, 24'h000111, 24'h000222, 0, 0, 0);
        idle(1);
        chk("ovr_set", overrun_out, 1);
        chk("ovr_novalid", valid_out, 0);
        idle(1);
        chk("ovr_valid", valid_out, 1);
        chk("ovr_a0", audio0_out, 24'h000010);
        step(0, 1, 0, 0, 0, 0, 1);
        idle(1);
        chk("clr_ovr", overrun_out, 0);
        chk("clr_a0", audio0_out, 0);
        // level load during MUL_L applies to the next sample only
        step(1, 1, 24'h000100, 24'h000200, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h40004000, 0);
        idle(2);
        chk("lvl_old_a0", audio0_out, 24'h000100);
        chk("lvl_old_a1", audio1_out, 24'h000200);
        idle(1);
        step(1, 1, 24'h000100, 24'h000200, 0, 0, 0);
        idle(3);
        chk("lvl_new_a0", audio0_out, 24'h000080);
        chk("lvl_new_a1", audio1_out, 24'h000100);
        // clear mid-operation
        idle(1);
        step(1, 1, 24'h001000, 24'h002000, 0, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 0, 1);
        idle(1);
        chk("midclr_valid", valid_out, 0);
        chk("midclr_a0", audio0_out, 0);
        chk("midclr_busy", busy_out, 0);
        // play off
        step(1, 0, 24'h001000, 24'h002000, 0, 0, 0);
        step(1, 0, 24'h001000, 24'h002000, 0, 0, 0);
        idle(2);
        chk("noplay_valid", valid_out, 0);
        chk("noplay_ovr", overrun_out, 0);
        chk("noplay_busy", busy_out, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] lr;
            logic [23:0] s0, s1;
            case ($urandom % 4)
                0: lr = 32'hFFFFFFFF;
                1: lr = 32'h80008000;
                default: lr = $urandom;
            endcase
            s0 = ($urandom % 8 == 0) ? 24'h800000 : 24'($urandom);
            s1 = ($urandom % 8 == 0) ? 24'h7FFFFF : 24'($urandom);
            step($urandom % 3 == 0, $urandom % 8 != 0, s0, s1, $urandom % 6 == 0, lr, $urandom % 40 == 0);
        end
        // asynchronous reset mid-operation
        idle(1);
        run = 0;
        step(1, 1, 24'h123456, 24'h654321, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("arst_pre_busy", busy_out, 1);
        rst = 1;
        #1;
        chk("arst_busy", busy_out, 0);
        chk("arst_a0", audio0_out, 0);
        chk("arst_a1", audio1_out, 0);
        chk("arst_ovr", overrun_out, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
